// File: rtl/kmap_pkg.sv
// rtl/kmap_pkg.sv - shared types and width helpers for the K-map sweeper
package kmap_pkg;

    localparam int KMAP_MAX_IN = 5;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    function automatic int TT_W(input int n);
        return 1 << n;
    endfunction

    function automatic int settle_cnt_w(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/kmap_settle_timer.sv
// rtl/kmap_settle_timer.sv - loadable down-counter timing the settle window of each vector
module kmap_settle_timer
    import kmap_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = settle_cnt_w(SETTLE);

    logic [CW-1:0] cnt;

    // cnt holds the window cycles still to come after the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // next cycle is the last one of the window
    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/kmap_sweeper.sv
// rtl/kmap_sweeper.sv - sweeps all K-map input vectors and captures f into a truth table
// Optional compare against a reference mask: KMAP_SWEEP_COMPARE_EN
module kmap_sweeper
    import kmap_pkg::*;
#(
    parameter int N_IN   = 5,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        vec,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [TT_W(N_IN)-1:0]  truth
`ifdef KMAP_SWEEP_COMPARE_EN
    ,
    input  logic [TT_W(N_IN)-1:0]  expected,
    output logic                   mismatch,
    output logic [N_IN-1:0]        first_bad
`endif
);

    state_t state, next_state;
    logic   accept, sample_now, last_vec, expire;

    assign last_vec = &vec;

    kmap_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept | sample_now),
        .expire (expire)
    );

    // SAMPLE is the final cycle of each window; with SETTLE == 1 it is the whole window
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample_now = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (SETTLE == 1) ? SAMPLE : DRIVE;
                end
            end
            DRIVE: begin
                if (expire) next_state = SAMPLE;
            end
            SAMPLE: begin
                sample_now = 1'b1;
                if (last_vec) next_state = DONE;
                else          next_state = (SETTLE == 1) ? SAMPLE : DRIVE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            vec   <= '0;
            truth <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                vec   <= '0;
                truth <= '0;
            end else if (sample_now) begin
                truth[vec] <= f_in;
                if (!last_vec) vec <= vec + N_IN'(1);
            end
        end
    end

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);

`ifdef KMAP_SWEEP_COMPARE_EN
    // only the first disagreement is latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else if (accept) begin
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else if (sample_now && !mismatch && (f_in != expected[vec])) begin
            mismatch  <= 1'b1;
            first_bad <= vec;
        end
    end
`endif

endmodule

// File: tb/tb_kmap_sweeper.sv
// tb/tb_kmap_sweeper.sv - randomized scoreboard bench for kmap_sweeper
module tb_kmap_sweeper;

    localparam int N  = 4;
    localparam int S  = 3;
    localparam int TW = 1 << N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          f_in;
    logic [N-1:0]  vec;
    logic          busy;
    logic          done;
    logic [TW-1:0] truth;
`ifdef KMAP_SWEEP_COMPARE_EN
    logic [TW-1:0] expected;
    logic          mismatch;
    logic [N-1:0]  first_bad;
`endif

    always #5 clk = ~clk;

    kmap_sweeper #(.N_IN(N), .SETTLE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec       (vec),
        .f_in      (f_in),
        .busy      (busy),
        .done      (done),
        .truth     (truth)
`ifdef KMAP_SWEEP_COMPARE_EN
        ,
        .expected  (expected),
        .mismatch  (mismatch),
        .first_bad (first_bad)
`endif
    );

    typedef struct {
        logic [TW-1:0] tt;
        logic          mm;
        logic [N-1:0]  fb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Truth-table masks built from the boolean function over the vector index
    function automatic logic [TW-1:0] mask_of(input int kind);
        logic [TW-1:0] m;
        logic [N-1:0]  idx;
        for (int i = 0; i < TW; i++) begin
            idx = N'(i);
            case (kind)
                0:       m[i] = &idx;
                1:       m[i] = ^idx;
                default: m[i] = 1'b1;
            endcase
        end
        return m;
    endfunction

    // Monitor: window lengths, vector order, sweep length, and scoreboard pops on done
    int           len = 0;
    int           run = 0;
    logic [N-1:0] prev_vec = '0;
    logic [N-1:0] next_vec;
    logic         prev_busy = 1'b0;
    logic         prev_done = 1'b0;
    exp_t         got;

    always @(negedge clk) begin
        if (rst) begin
            len       = 0;
            run       = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy || done) len++;
            else              len = 0;
            if (busy) begin
                if (prev_busy && vec == prev_vec) begin
                    run++;
                end else begin
                    if (prev_busy) begin
                        next_vec = prev_vec + N'(1);
                        check("vec_hold", run, S);
                        check("vec_step", vec, next_vec);
                    end else begin
                        check("vec_first", vec, 0);
                    end
                    run = 1;
                end
            end
            if (done) begin
                check("done_single", prev_done, 0);
                check("last_hold", run, S);
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("truth", truth, got.tt);
                    check("vec_final", vec, TW - 1);
                    check("sweep_len", len, TW * S + 1);
`ifdef KMAP_SWEEP_COMPARE_EN
                    check("mismatch", mismatch, got.mm);
                    check("first_bad", first_bad, got.fb);
`endif
                end
            end
            prev_busy = busy;
            prev_vec  = vec;
            prev_done = done;
        end
    end

    // One sweep; f_in is only meaningful in the last cycle of each window, noise otherwise
    task automatic sweep(input logic [TW-1:0] fmask, input logic [TW-1:0] emask,
                         input int restart_at, input bit start_in_done);
        exp_t e;
        e.tt = fmask;
        e.mm = (fmask != emask);
        e.fb = '0;
        for (int i = TW - 1; i >= 0; i--) if (fmask[i] != emask[i]) e.fb = N'(i);
        @(negedge clk);
        start = 1'b1;
`ifdef KMAP_SWEEP_COMPARE_EN
        expected = emask;
`endif
        sb.push_back(e);
        for (int c = 0; c < TW * S; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            f_in  = ((c % S) == S - 1) ? fmask[c / S] : 1'($urandom);
        end
        @(negedge clk);
        start = start_in_done;
        f_in  = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        exp_t dummy;
        rst   = 1'b1;
        start = 1'b0;
        f_in  = 1'b0;
`ifdef KMAP_SWEEP_COMPARE_EN
        expected = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_vec", vec, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_truth", truth, 0);

        sweep(mask_of(0), mask_of(0), -1, 1'b0);
        sweep(mask_of(1), mask_of(1), -1, 1'b0);
        sweep(mask_of(1), mask_of(1), 10, 1'b1);
        sweep(mask_of(0), 16'h8800, -1, 1'b0);
        sweep(mask_of(0), 16'h8000, -1, 1'b0);

        // reset seven cycles into a sweep that has already captured ones
        dummy.tt = '1;
        dummy.mm = 1'b0;
        dummy.fb = '0;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(dummy);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            f_in  = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_vec", vec, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_truth", truth, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(mask_of(2), mask_of(2), -1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            logic [TW-1:0] fm;
            logic [TW-1:0] em;
            fm = TW'($urandom);
            em = (k[0]) ? fm : TW'($urandom);
            sweep(fm, em, $urandom_range(0, TW * S - 1), k[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
